// File: rtl/rf_writeback_arbiter.sv
// Sole register-file writer: merges ALU results with FIFO-buffered load returns and stalls the ALU if loads starve.
// Optional macro RF_WB_PENDING_EN enables the PEND_MASK hazard scoreboard; otherwise PEND_MASK is tied to zero.
module rf_writeback_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ALU_VALID,
  input  logic [4:0]  ALU_WA,
  input  logic [31:0] ALU_WD,
  output logic        ALU_STALL,
  input  logic        LD_VALID,
  output logic        LD_READY,
  input  logic [4:0]  LD_WA,
  input  logic [31:0] LD_WD,
  output logic        RF_EN,
  output logic [4:0]  RF_WA,
  output logic [31:0] RF_WD,
  output logic [31:0] PEND_MASK
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ld_ent_t;

  ld_ent_t       mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rf_en_q, rf_en_d;
  logic [4:0]    rf_wa_q, rf_wa_d;
  logic [31:0]   rf_wd_q, rf_wd_d;

  logic    empty, full, starved, push, pop;
  ld_ent_t head;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign starved = (starve_q == SW'(STARVE_MAX)) && !empty;

  // Loads to x0 complete the handshake but never occupy a slot.
  assign push = LD_VALID && !full && (LD_WA != 5'd0);
  assign pop  = starved || (!ALU_VALID && !empty);

  assign ALU_STALL = starved;
  assign LD_READY  = !full;
  assign RF_EN     = rf_en_q;
  assign RF_WA     = rf_wa_q;
  assign RF_WD     = rf_wd_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    starve_d = starve_q;
    rf_en_d  = 1'b0;
    rf_wa_d  = rf_wa_q;
    rf_wd_d  = rf_wd_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rf_en_d  = 1'b1;
      rf_wa_d  = head.wa;
      rf_wd_d  = head.wd;
    end else if (ALU_VALID && (ALU_WA != 5'd0)) begin
      rf_en_d = 1'b1;
      rf_wa_d = ALU_WA;
      rf_wd_d = ALU_WD;
    end

    // Without a pop and with entries waiting, ALU_VALID must have won the slot.
    if (pop || empty) begin
      starve_d = '0;
    end else if (ALU_VALID && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      starve_q <= '0;
      rf_en_q  <= 1'b0;
      rf_wa_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      starve_q <= starve_d;
      rf_en_q  <= rf_en_d;
      rf_wa_q  <= rf_wa_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{wa: LD_WA, wd: LD_WD};
  end

`ifdef RF_WB_PENDING_EN
  logic [AW:0]  count;
  logic [31:0]  pend;

  assign count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((AW+1)'(i) < count) pend[mem_q[rd_ptr_q[AW-1:0] + AW'(i)].wa] = 1'b1;
    end
    if (rf_en_q) pend[rf_wa_q] = 1'b1;
    pend[0] = 1'b0;
  end

  assign PEND_MASK = pend;
`else
  assign PEND_MASK = 32'h0;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: vector table plus starvation/full/reset sequences.
module tb_rf_writeback_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ALU_VALID;
  logic [4:0]  ALU_WA;
  logic [31:0] ALU_WD;
  logic        ALU_STALL;
  logic        LD_VALID;
  logic        LD_READY;
  logic [4:0]  LD_WA;
  logic [31:0] LD_WD;
  logic        RF_EN;
  logic [4:0]  RF_WA;
  logic [31:0] RF_WD;
  logic [31:0] PEND_MASK;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  rf_writeback_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ALU_VALID(ALU_VALID), .ALU_WA(ALU_WA), .ALU_WD(ALU_WD), .ALU_STALL(ALU_STALL),
    .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_WA(LD_WA), .LD_WD(LD_WD),
    .RF_EN(RF_EN), .RF_WA(RF_WA), .RF_WD(RF_WD), .PEND_MASK(PEND_MASK)
  );

  typedef struct {
    logic        av;
    logic [4:0]  awa;
    logic [31:0] awd;
    logic        lv;
    logic [4:0]  lwa;
    logic [31:0] lwd;
    logic        x_stall;
    logic        x_ready;
    logic [31:0] x_pend;
    logic        x_en;
    logic [4:0]  x_wa;
    logic [31:0] x_wd;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  function automatic vec_t mk(logic av, logic [4:0] awa, logic [31:0] awd,
                              logic lv, logic [4:0] lwa, logic [31:0] lwd,
                              logic st, logic rd, logic [31:0] pm,
                              logic en, logic [4:0] wa, logic [31:0] wd);
    vec_t v;
    v.av = av; v.awa = awa; v.awd = awd;
    v.lv = lv; v.lwa = lwa; v.lwd = lwd;
    v.x_stall = st; v.x_ready = rd; v.x_pend = pm;
    v.x_en = en; v.x_wa = wa; v.x_wd = wd;
    return v;
  endfunction

  function automatic logic [31:0] pend_exp(logic [31:0] p);
`ifdef RF_WB_PENDING_EN
    return p;
`else
    return (p & 32'h0);
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic av, logic [4:0] awa, logic [31:0] awd,
                       logic lv, logic [4:0] lwa, logic [31:0] lwd);
    ALU_VALID = av; ALU_WA = awa; ALU_WD = awd;
    LD_VALID = lv; LD_WA = lwa; LD_WD = lwd;
  endtask

  task automatic edge_out();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // av awa awd            lv lwa ld_wd          stall rdy pend          en wa  wd
    vt[0]  = mk(0, 0,  0,             0, 0, 0,          0, 1, 32'h0,    0, 0,  0);
    vt[1]  = mk(1, 5,  32'hDEADBEEF,  0, 0, 0,          0, 1, 32'h0,    1, 5,  32'hDEADBEEF);
    vt[2]  = mk(0, 0,  0,             0, 0, 0,          0, 1, 32'h20,   0, 5,  32'hDEADBEEF);
    vt[3]  = mk(0, 0,  0,             1, 1, 32'hD1,     0, 1, 32'h0,    0, 5,  32'hDEADBEEF);
    vt[4]  = mk(0, 0,  0,             1, 2, 32'hD2,     0, 1, 32'h2,    1, 1,  32'hD1);
    vt[5]  = mk(0, 0,  0,             1, 3, 32'hD3,     0, 1, 32'h6,    1, 2,  32'hD2);
    vt[6]  = mk(0, 0,  0,             1, 4, 32'hD4,     0, 1, 32'hC,    1, 3,  32'hD3);
    vt[7]  = mk(0, 0,  0,             0, 0, 0,          0, 1, 32'h18,   1, 4,  32'hD4);
    vt[8]  = mk(0, 0,  0,             0, 0, 0,          0, 1, 32'h10,   0, 4,  32'hD4);
    vt[9]  = mk(1, 9,  32'hA0,        1, 7, 32'hD7,     0, 1, 32'h0,    1, 9,  32'hA0);
    vt[10] = mk(1, 10, 32'hA1,        0, 0, 0,          0, 1, 32'h280,  1, 10, 32'hA1);
    vt[11] = mk(1, 11, 32'hA2,        0, 0, 0,          0, 1, 32'h480,  1, 11, 32'hA2);
    vt[12] = mk(1, 12, 32'hA3,        0, 0, 0,          0, 1, 32'h880,  1, 12, 32'hA3);
    vt[13] = mk(1, 13, 32'hA4,        0, 0, 0,          1, 1, 32'h1080, 1, 7,  32'hD7);
    vt[14] = mk(1, 13, 32'hA4,        0, 0, 0,          0, 1, 32'h80,   1, 13, 32'hA4);
    vt[15] = mk(1, 0,  32'h55,        1, 0, 32'h66,     0, 1, 32'h2000, 0, 13, 32'hA4);
    vt[16] = mk(0, 0,  0,             0, 0, 0,          0, 1, 32'h0,    0, 13, 32'hA4);

    RST_N = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_rf_en", 32'(RF_EN), 32'h0);
    chk("reset_rf_wa", 32'(RF_WA), 32'h0);
    chk("reset_rf_wd", RF_WD, 32'h0);
    chk("reset_ld_ready", 32'(LD_READY), 32'h1);
    chk("reset_alu_stall", 32'(ALU_STALL), 32'h0);
    chk("reset_pend", PEND_MASK, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    edge_out();

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].av, vt[i].awa, vt[i].awd, vt[i].lv, vt[i].lwa, vt[i].lwd);
      @(negedge CLK);
      chk($sformatf("v%0d_stall", i), 32'(ALU_STALL), 32'(vt[i].x_stall));
      chk($sformatf("v%0d_ready", i), 32'(LD_READY), 32'(vt[i].x_ready));
      chk($sformatf("v%0d_pend", i), PEND_MASK, pend_exp(vt[i].x_pend));
      edge_out();
      chk($sformatf("v%0d_rf_en", i), 32'(RF_EN), 32'(vt[i].x_en));
      chk($sformatf("v%0d_rf_wa", i), 32'(RF_WA), 32'(vt[i].x_wa));
      chk($sformatf("v%0d_rf_wd", i), RF_WD, vt[i].x_wd);
    end

    // Fill the FIFO behind a busy ALU; the 5th load must wait for the first pop.
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(20 + i), 32'hA000 + 32'(i), 1, 5'(i + 1), 32'h100 + 32'(i + 1));
      edge_out();
      chk($sformatf("fill%0d_rf_wa", i), 32'(RF_WA), 32'(20 + i));
    end
    drive(1, 5'd24, 32'hA004, 1, 5'd5, 32'h105);
    @(negedge CLK);
    chk("full_ld_ready", 32'(LD_READY), 32'h0);
    chk("full_alu_stall", 32'(ALU_STALL), 32'h1);
    edge_out();
    chk("full_pop_rf_en", 32'(RF_EN), 32'h1);
    chk("full_pop_rf_wa", 32'(RF_WA), 32'h1);
    chk("full_pop_rf_wd", RF_WD, 32'h101);
    @(negedge CLK);
    chk("after_pop_ld_ready", 32'(LD_READY), 32'h1);
    chk("after_pop_alu_stall", 32'(ALU_STALL), 32'h0);
    edge_out();
    chk("held_alu_rf_wa", 32'(RF_WA), 32'd24);
    chk("held_alu_rf_wd", RF_WD, 32'hA004);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 2; k <= 5; k++) begin
      edge_out();
      chk($sformatf("drain%0d_rf_en", k), 32'(RF_EN), 32'h1);
      chk($sformatf("drain%0d_rf_wa", k), 32'(RF_WA), 32'(k));
      chk($sformatf("drain%0d_rf_wd", k), RF_WD, 32'h100 + 32'(k));
    end
    edge_out();
    chk("drained_rf_en", 32'(RF_EN), 32'h0);

    // Async reset with three loads buffered.
    for (int i = 1; i <= 3; i++) begin
      drive(1, 5'd6, 32'hB000 + 32'(i), 1, 5'(8 + i), 32'hC000 + 32'(i));
      edge_out();
    end
    drive(0, 0, 0, 0, 0, 0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrst_rf_en", 32'(RF_EN), 32'h0);
    chk("midrst_rf_wa", 32'(RF_WA), 32'h0);
    chk("midrst_rf_wd", RF_WD, 32'h0);
    chk("midrst_ld_ready", 32'(LD_READY), 32'h1);
    chk("midrst_alu_stall", 32'(ALU_STALL), 32'h0);
    chk("midrst_pend", PEND_MASK, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edge_out();
      chk($sformatf("postrst%0d_rf_en", i), 32'(RF_EN), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
